alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/riscv_pkg.sv | 27 ++
 rtl/alu.sv | 41 ++++
 rtl/alu_arbiter.sv | 105 ++++++++++
 tb/tb_alu_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared core types: ALU operation encoding, datapath width and
// the state encoding of the shared-ALU arbiter.
package riscv_pkg;

    localparam int XLEN = 32;
    localparam int OPW  = 4;

    typedef enum logic [OPW-1:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9
    } alu_op_e;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_EXEC = 2'd1,
        ARB_RESP = 2'd2
    } arb_state_e;

endpackage

// File: rtl/alu.sv
// Combinational integer ALU shared by the core; undefined
// operation encodings produce zero.
module alu
    import riscv_pkg::*;
(
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    input  alu_op_e         op_i,
    output logic [XLEN-1:0] res_o
);

    localparam int SHW = $clog2(XLEN);

    logic [SHW-1:0]         w_shamt;
    logic signed [XLEN-1:0] w_sra;
    logic                   w_lt;
    logic                   w_ltu;

    assign w_shamt = b_i[SHW-1:0];
    assign w_sra   = $signed(a_i) >>> w_shamt;
    assign w_lt    = $signed(a_i) < $signed(b_i);
    assign w_ltu   = a_i < b_i;

    always_comb begin
        res_o = '0;
        case (op_i)
            ALU_ADD:  res_o = a_i + b_i;
            ALU_SUB:  res_o = a_i - b_i;
            ALU_SLL:  res_o = a_i << w_shamt;
            ALU_SLT:  res_o = {{(XLEN-1){1'b0}}, w_lt};
            ALU_SLTU: res_o = {{(XLEN-1){1'b0}}, w_ltu};
            ALU_XOR:  res_o = a_i ^ b_i;
            ALU_SRL:  res_o = a_i >> w_shamt;
            ALU_SRA:  res_o = w_sra;
            ALU_OR:   res_o = a_i | b_i;
            ALU_AND:  res_o = a_i & b_i;
            default:  res_o = '0;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between NREQ requesters;
// one operation in flight, result held until its owner consumes it.
module alu_arbiter
    import riscv_pkg::*;
#(
    parameter int NREQ = 3,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [NREQ-1:0]      req_valid_i,
    output logic [NREQ-1:0]      req_ready_o,
    input  logic [NREQ*XLEN-1:0] req_a_i,
    input  logic [NREQ*XLEN-1:0] req_b_i,
    input  logic [NREQ*OPW-1:0]  req_op_i,
    output logic [NREQ-1:0]      rsp_valid_o,
    input  logic [NREQ-1:0]      rsp_ready_i,
    output logic [XLEN-1:0]      rsp_result_o,
    output logic                 busy_o
);

    arb_state_e      r_state;
    logic [IDW-1:0]  r_last;
    logic [IDW-1:0]  r_id;
    logic [XLEN-1:0] r_a;
    logic [XLEN-1:0] r_b;
    logic [OPW-1:0]  r_op;
    logic [XLEN-1:0] r_result;
    logic [NREQ-1:0] r_rsp_valid;

    logic            w_gnt_any;
    logic [IDW-1:0]  w_gnt_id;
    logic            w_hs;
    logic [XLEN-1:0] w_alu_res;

    // Search starts just after the last granted requester.
    always_comb begin
        w_gnt_any = 1'b0;
        w_gnt_id  = '0;
        for (int i = 1; i <= NREQ; i++) begin
            if (!w_gnt_any && req_valid_i[(int'(r_last) + i) % NREQ]) begin
                w_gnt_any = 1'b1;
                w_gnt_id  = IDW'((int'(r_last) + i) % NREQ);
            end
        end
    end

    assign w_hs = (r_state == ARB_IDLE) && w_gnt_any;

    always_comb begin
        req_ready_o = '0;
        if (w_hs)
            req_ready_o[w_gnt_id] = 1'b1;
    end

    alu u_alu (
        .a_i   (r_a),
        .b_i   (r_b),
        .op_i  (alu_op_e'(r_op)),
        .res_o (w_alu_res)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state     <= ARB_IDLE;
            r_last      <= IDW'(NREQ - 1);
            r_id        <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_op        <= '0;
            r_result    <= '0;
            r_rsp_valid <= '0;
        end else begin
            unique case (r_state)
                ARB_IDLE: begin
                    if (w_hs) begin
                        r_a     <= req_a_i[w_gnt_id*XLEN +: XLEN];
                        r_b     <= req_b_i[w_gnt_id*XLEN +: XLEN];
                        r_op    <= req_op_i[w_gnt_id*OPW +: OPW];
                        r_id    <= w_gnt_id;
                        r_last  <= w_gnt_id;
                        r_state <= ARB_EXEC;
                    end
                end
                ARB_EXEC: begin
                    r_result          <= w_alu_res;
                    r_rsp_valid[r_id] <= 1'b1;
                    r_state           <= ARB_RESP;
                end
                ARB_RESP: begin
                    if (rsp_ready_i[r_id]) begin
                        r_rsp_valid <= '0;
                        r_state     <= ARB_IDLE;
                    end
                end
                default: r_state <= ARB_IDLE;
            endcase
        end
    end

    assign rsp_valid_o  = r_rsp_valid;
    assign rsp_result_o = r_result;
    assign busy_o       = (r_state != ARB_IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: cycle model with result scoreboard plus
// table-driven vectors and directed hold/reset/round-robin sequences.
module tb_alu_arbiter;
    import riscv_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  req_valid = '0;
    logic [2:0]  req_ready;
    logic [95:0] req_a = '0;
    logic [95:0] req_b = '0;
    logic [11:0] req_op = '0;
    logic [2:0]  rsp_valid;
    logic [2:0]  rsp_ready = '0;
    logic [31:0] rsp_result;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;
    int n_hs    = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.NREQ(3)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_a_i      (req_a),
        .req_b_i      (req_b),
        .req_op_i     (req_op),
        .rsp_valid_o  (rsp_valid),
        .rsp_ready_i  (rsp_ready),
        .rsp_result_o (rsp_result),
        .busy_o       (busy)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_alu(input logic [3:0] op,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
        logic [4:0]  s;
        logic [31:0] ones;
        s    = b[4:0];
        ones = 32'hFFFF_FFFF;
        case (op)
            4'd0: return a + b;
            4'd1: return a - b;
            4'd2: return a << s;
            4'd3: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd4: return (a < b) ? 32'd1 : 32'd0;
            4'd5: return a ^ b;
            4'd6: return a >> s;
            4'd7: return (a >> s) | (a[31] ? ~(ones >> s) : 32'd0);
            4'd8: return a | b;
            4'd9: return a & b;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [2:0] rr(input logic [2:0] v, input int last);
        for (int i = 1; i <= 3; i++) begin
            int k;
            k = (last + i) % 3;
            if (v[k]) return 3'b001 << k;
        end
        return 3'b000;
    endfunction

    // Cycle model: 0 idle, 1 exec, 2 resp
    int          m_phase = 0;
    int          m_id    = 0;
    int          m_last  = 2;
    logic [31:0] sb[$];

    always @(negedge clk) begin
        logic [2:0] eg;
        if (rst) begin
            chk("rst_ready", {29'd0, req_ready}, 32'd0);
            chk("rst_rsp_valid", {29'd0, rsp_valid}, 32'd0);
            chk("rst_result", rsp_result, 32'd0);
            chk("rst_busy", {31'd0, busy}, 32'd0);
            m_phase = 0;
            m_last  = 2;
            sb.delete();
        end else begin
            eg = (m_phase == 0) ? rr(req_valid, m_last) : 3'b000;
            chk("mdl_ready", {29'd0, req_ready}, {29'd0, eg});
            chk("mdl_rsp_valid", {29'd0, rsp_valid},
                (m_phase == 2) ? (32'd1 << m_id) : 32'd0);
            chk("mdl_busy", {31'd0, busy}, {31'd0, m_phase != 0});
            if (rsp_valid != 3'b000)
                chk("onehot", {31'd0, $onehot(rsp_valid)}, 32'd1);
            case (m_phase)
                0: begin
                    if (eg != 3'b000) begin
                        for (int k = 0; k < 3; k++)
                            if (eg[k]) m_id = k;
                        m_last = m_id;
                        sb.push_back(ref_alu(req_op[m_id*4 +: 4],
                                             req_a[m_id*32 +: 32],
                                             req_b[m_id*32 +: 32]));
                        n_hs++;
                        m_phase = 1;
                    end
                end
                1: m_phase = 2;
                default: begin
                    if (sb.size() == 0) begin
                        chk("sb_nonempty", 32'd0, 32'd1);
                    end else begin
                        chk("sb_result", rsp_result, sb[0]);
                        if (rsp_ready[m_id]) begin
                            void'(sb.pop_front());
                            m_phase = 0;
                        end
                    end
                end
            endcase
        end
    end

    typedef struct {
        int          id;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        string       nm;
    } vec_t;

    task automatic set_req(input int id, input logic [3:0] op,
                           input logic [31:0] a, input logic [31:0] b);
        req_op[id*4 +: 4]  = op;
        req_a[id*32 +: 32] = a;
        req_b[id*32 +: 32] = b;
    endtask

    task automatic drain();
        req_valid = '0;
        rsp_ready = 3'b111;
        repeat (4) @(posedge clk);
        #1;
        rsp_ready = '0;
    endtask

    // Lone request: ready same cycle, response two cycles later
    task automatic single(input vec_t v);
        set_req(v.id, v.op, v.a, v.b);
        req_valid = 3'b001 << v.id;
        @(negedge clk);
        chk({v.nm, "_ready"}, {29'd0, req_ready}, 32'd1 << v.id);
        @(posedge clk); #1;
        req_valid = '0;
        @(negedge clk);
        chk({v.nm, "_lat1"}, {29'd0, rsp_valid}, 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk({v.nm, "_valid"}, {29'd0, rsp_valid}, 32'd1 << v.id);
        chk({v.nm, "_result"}, rsp_result, v.exp);
        @(posedge clk); #1;
        rsp_ready = 3'b001 << v.id;
        @(posedge clk); #1;
        rsp_ready = '0;
    endtask

    initial begin
        vec_t tbl[11];
        int   gid[4];
        int   gcyc[4];
        int   ng;
        int   exp_id[4];
        int   exp_cyc[4];
        int   hs0;
        int   cyc;

        tbl[0]  = '{1, 4'd0, 32'd5,         32'd7,         32'd12,        "add"};
        tbl[1]  = '{0, 4'd7, 32'h8000_0000, 32'h24,        32'hF800_0000, "sra"};
        tbl[2]  = '{0, 4'd4, 32'd1,         32'hFFFF_FFFF, 32'd1,         "sltu"};
        tbl[3]  = '{2, 4'd1, 32'd3,         32'd5,         32'hFFFF_FFFE, "sub"};
        tbl[4]  = '{1, 4'd3, 32'hFFFF_FFFF, 32'd1,         32'd1,         "slt"};
        tbl[5]  = '{2, 4'd2, 32'd1,         32'h21,        32'd2,         "sll"};
        tbl[6]  = '{0, 4'd6, 32'h8000_0000, 32'd31,        32'd1,         "srl"};
        tbl[7]  = '{1, 4'd5, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, "xor"};
        tbl[8]  = '{2, 4'd8, 32'h1234_0000, 32'h5678,      32'h1234_5678, "or"};
        tbl[9]  = '{0, 4'd9, 32'hFFFF_0000, 32'h1234_5678, 32'h1234_0000, "and"};
        tbl[10] = '{1, 4'd15, 32'd1,        32'd2,         32'd0,         "undef"};

        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // All three request continuously; responses consumed at once
        for (int k = 0; k < 3; k++) set_req(k, 4'd0, 32'(k * 100), 32'd1);
        req_valid = 3'b111;
        rsp_ready = 3'b111;
        ng = 0;
        exp_id  = '{0, 1, 2, 0};
        exp_cyc = '{0, 3, 6, 9};
        gid  = '{-1, -1, -1, -1};
        gcyc = '{-1, -1, -1, -1};
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (req_ready != 3'b000 && ng < 4) begin
                for (int k = 0; k < 3; k++)
                    if (req_ready[k]) gid[ng] = k;
                gcyc[ng] = c;
                ng++;
            end
        end
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("rr_order%0d", k), 32'(gid[k]), 32'(exp_id[k]));
            chk($sformatf("rr_cycle%0d", k), 32'(gcyc[k]), 32'(exp_cyc[k]));
        end
        @(posedge clk); #1;
        drain();

        for (int i = 0; i < 11; i++) single(tbl[i]);
        drain();

        // Response held while only a foreign ready bit is set
        set_req(2, 4'd0, 32'h100, 32'h23);
        req_valid = 3'b100;
        @(negedge clk);
        chk("hold_ready", {29'd0, req_ready}, 32'd4);
        @(posedge clk); #1;
        req_valid = 3'b011;
        rsp_ready = 3'b001;
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_noready", {29'd0, req_ready}, 32'd0);
            chk("hold_valid", {29'd0, rsp_valid}, 32'd4);
            chk("hold_result", rsp_result, 32'h123);
            @(posedge clk); #1;
        end
        rsp_ready = 3'b101;
        @(negedge clk);
        chk("hold_valid_last", {29'd0, rsp_valid}, 32'd4);
        @(posedge clk); #1;
        rsp_ready = '0;
        @(negedge clk);
        chk("hold_released", {29'd0, rsp_valid}, 32'd0);
        chk("hold_next_grant", {29'd0, req_ready}, 32'd1);
        @(posedge clk); #1;
        drain();

        // Reset while an operation is executing
        set_req(1, 4'd0, 32'd40, 32'd2);
        req_valid = 3'b010;
        @(posedge clk); #1;
        req_valid = '0;
        chk("rstx_busy_before", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("rstx_ready", {29'd0, req_ready}, 32'd0);
        chk("rstx_valid", {29'd0, rsp_valid}, 32'd0);
        chk("rstx_result", rsp_result, 32'd0);
        chk("rstx_busy", {31'd0, busy}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        req_valid = 3'b111;
        rsp_ready = 3'b111;
        @(negedge clk);
        chk("rstx_first_grant", {29'd0, req_ready}, 32'd1);
        @(posedge clk); #1;
        drain();

        // Random traffic checked by the model and scoreboard
        hs0 = n_hs;
        cyc = 0;
        while ((n_hs - hs0) < 10000 && cyc < 60000) begin
            for (int k = 0; k < 3; k++) begin
                logic [3:0] op;
                op = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15))
                                                 : 4'($urandom_range(0, 9));
                set_req(k, op, $urandom, $urandom);
            end
            req_valid = 3'($urandom_range(0, 7));
            rsp_ready = 3'($urandom | $urandom);
            @(posedge clk); #1;
            cyc++;
        end
        chk("rand_10k_done", {31'd0, (n_hs - hs0) >= 10000}, 32'd1);
        drain();
        @(negedge clk);
        chk("final_idle", {31'd0, busy}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
